commit_trace_checker: RTL

//  Consumes the CPU's per-instruction commit stream (register and memory writebacks) and checks it
//  in order against a golden trace that the bench pushes into an internal FIFO.

---
 rtl/commit_trace_checker_pkg.sv | 28 ++
 rtl/commit_trace_checker_fifo.sv | 55 +++++
 rtl/commit_trace_checker.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/commit_trace_checker_pkg.sv
// Shared encodings for the commit trace checker: entry kinds, error codes, FSM states, entry layout.
// Pure declarations; no latency or flow control of its own.
// Backpressure is handled by the FIFO and checker that import this package.
package trace_pkg;

    localparam logic KIND_GRF = 1'b0;
    localparam logic KIND_DM  = 1'b1;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISMATCH = 2'd1;
    localparam logic [1:0] ERR_UNDERRUN = 2'd2;
    localparam logic [1:0] ERR_MISSING  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_e;

    typedef struct packed {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } trace_entry_t;

endpackage

// File: rtl/commit_trace_checker_fifo.sv
// Golden-entry FIFO: DEPTH x 97-bit, head visible combinationally, extra wrap bit on pointers.
// Latency: a pushed entry is at the head the cycle after the push edge.
// Backpressure: pushes while full and pops while empty are dropped; full comes from registered pointers.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  trace_entry_t din,
    output trace_entry_t head,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count
);

    trace_entry_t mem [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign head    = mem[rd_ptr_q[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset: stale slots are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/commit_trace_checker.sv
// In-order checker of the CPU commit stream against a queued golden trace, with a sticky verdict.
// Latency: each commit is compared against the FIFO head in its own cycle; verdict registers on that edge.
// Backpressure: exp_ready drops when the FIFO is full or the verdict is FAIL; commits are never stalled.
module commit_trace_checker
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cm_valid,
    input  logic             cm_kind,
    input  logic [31:0]      cm_pc,
    input  logic [31:0]      cm_addr,
    input  logic [31:0]      cm_data,
    input  logic             exp_valid,
    output logic             exp_ready,
    input  logic             exp_kind,
    input  logic [31:0]      exp_pc,
    input  logic [31:0]      exp_addr,
    input  logic [31:0]      exp_data,
    input  logic             done_i,
    output logic [CNT_W-1:0] match_cnt,
    output logic [1:0]       state_o,
    output logic [1:0]       err_code,
    output logic [31:0]      err_pc,
    output logic [CNT_W-1:0] err_idx
);

    localparam int AW = $clog2(DEPTH);

    state_e           st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       code_q, code_d;
    logic [31:0]      epc_q, epc_d;
    logic [CNT_W-1:0] idx_q, idx_d;

    trace_entry_t cm_ent, exp_ent, head;
    logic         full, empty, push, pop, cm_take, fail;
    logic [1:0]   fail_code;
    logic [AW:0]  count;

    assign cm_ent  = '{kind: cm_kind, pc: cm_pc, addr: cm_addr, data: cm_data};
    assign exp_ent = '{kind: exp_kind, pc: exp_pc, addr: exp_addr, data: exp_data};

    // Writes to $0 are architecturally invisible and never appear in the golden trace.
    assign cm_take   = cm_valid && !(cm_kind == KIND_GRF && cm_addr == 32'd0);
    assign exp_ready = !full && (st_q != ST_FAIL);
    assign push      = exp_valid && exp_ready;

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (push),
        .pop   (pop),
        .din   (exp_ent),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        st_d      = st_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        epc_d     = epc_q;
        idx_d     = idx_q;
        pop       = 1'b0;
        fail      = 1'b0;
        fail_code = ERR_NONE;
        case (st_q)
            ST_IDLE, ST_RUN: begin
                if (cm_take) begin
                    if (empty) begin
                        fail      = 1'b1;
                        fail_code = ERR_UNDERRUN;
                    end else if (cm_ent != head) begin
                        fail      = 1'b1;
                        fail_code = ERR_MISMATCH;
                    end else begin
                        pop = 1'b1;
                        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                    end
                end
                if (fail) begin
                    st_d   = ST_FAIL;
                    code_d = fail_code;
                    epc_d  = cm_pc;
                    idx_d  = cnt_q;
                end else if (done_i) begin
                    // A same-cycle pop of the last entry still counts as drained.
                    if (st_q == ST_IDLE || count == {{AW{1'b0}}, pop}) begin
                        st_d = ST_PASS;
                    end else begin
                        st_d   = ST_FAIL;
                        code_d = ERR_MISSING;
                        epc_d  = 32'd0;
                        idx_d  = cnt_d;
                    end
                end else if (st_q == ST_IDLE && (push || cm_take)) begin
                    st_d = ST_RUN;
                end
            end
            ST_PASS: begin
                if (cm_take) begin
                    st_d   = ST_FAIL;
                    code_d = ERR_UNDERRUN;
                    epc_d  = cm_pc;
                    idx_d  = cnt_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q   <= ST_IDLE;
            cnt_q  <= '0;
            code_q <= ERR_NONE;
            epc_q  <= '0;
            idx_q  <= '0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            code_q <= code_d;
            epc_q  <= epc_d;
            idx_q  <= idx_d;
        end
    end

    assign match_cnt = cnt_q;
    assign state_o   = st_q;
    assign err_code  = code_q;
    assign err_pc    = epc_q;
    assign err_idx   = idx_q;

endmodule
